// File: rtl/alarm_melody.sv
// Alarm tone generator: plays a fixed melody on a piezo pin with snooze,
// repeat limit and auto-stop. The beat enable is derived from the system clock.
module alarm_melody #(
    parameter int CLK_HZ       = 1000000,
    parameter int BEAT_DIV     = 250000,
    parameter int SEQ_LEN      = 16,
    parameter int REPEATS      = 3,
    parameter int SNOOZE_BEATS = 40,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       snooze,
    output logic       piezo,
    output logic       led,
    output logic       busy,
    output logic [3:0] note_idx,
    output logic       done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PLAY   = 2'd1;
    localparam logic [1:0] S_SNOOZE = 2'd2;

    localparam int BW = $clog2(BEAT_DIV);
    localparam int PW = (REPEATS < 2) ? 1 : $clog2(REPEATS);
    localparam int SW = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);
    localparam int NW = (SNOOZE_BEATS < 2) ? 1 : $clog2(SNOOZE_BEATS);

    localparam logic [BW-1:0] BEAT_LAST   = BW'(BEAT_DIV - 1);
    localparam logic [BW-1:0] BEAT_HALF   = BW'(BEAT_DIV / 2);
    localparam logic [3:0]    NOTE_LAST   = 4'(SEQ_LEN - 1);
    localparam logic [PW-1:0] PASS_LAST   = PW'((REPEATS == 0) ? 0 : REPEATS - 1);
    localparam logic [SW-1:0] SNOOZE_MAX  = SW'(MAX_SNOOZE);
    localparam logic [NW-1:0] SNOOZE_LAST = NW'(SNOOZE_BEATS - 1);

    function automatic logic [15:0] half_period(input int freq);
        int hp;
        hp = CLK_HZ / (2 * freq);
        return (hp < 1) ? 16'd1 : 16'(hp);
    endfunction

    localparam logic [15:0] HP_C4 = half_period(262);
    localparam logic [15:0] HP_D4 = half_period(294);
    localparam logic [15:0] HP_E4 = half_period(330);
    localparam logic [15:0] HP_F4 = half_period(349);
    localparam logic [15:0] HP_G4 = half_period(392);
    localparam logic [15:0] HP_A4 = half_period(440);
    localparam logic [15:0] HP_B4 = half_period(494);
    localparam logic [15:0] HP_C5 = half_period(523);

    logic [1:0]    state;
    logic [BW-1:0] beat_cnt;
    logic [PW-1:0] pass_cnt;
    logic [SW-1:0] snooze_cnt;
    logic [NW-1:0] snooze_beats;
    logic [15:0]   tone_cnt;
    logic          start_q, stop_q, snooze_q;
    logic [3:0]    code;
    logic [15:0]   hp;

    logic start_e, stop_e, snooze_e, tick, snooze_go, tone_run;

    assign start_e   = start & ~start_q;
    assign stop_e    = stop & ~stop_q;
    assign snooze_e  = snooze & ~snooze_q;
    assign tick      = (state != S_IDLE) && (beat_cnt == BEAT_LAST);
    assign snooze_go = (state == S_PLAY) && !stop_e && snooze_e && (snooze_cnt < SNOOZE_MAX);
    assign tone_run  = (state == S_PLAY) && !stop_e && !snooze_go && !tick && (code != 4'd0);
    assign busy      = (state != S_IDLE);

    always_comb begin
        code = 4'd0;
        case (note_idx)
            4'd0:  code = 4'd1;
            4'd1:  code = 4'd3;
            4'd2:  code = 4'd5;
            4'd3:  code = 4'd8;
            4'd4:  code = 4'd0;
            4'd5:  code = 4'd8;
            4'd6:  code = 4'd5;
            4'd7:  code = 4'd3;
            4'd8:  code = 4'd1;
            4'd9:  code = 4'd0;
            4'd10: code = 4'd1;
            4'd11: code = 4'd3;
            4'd12: code = 4'd5;
            4'd13: code = 4'd8;
            4'd14: code = 4'd8;
            4'd15: code = 4'd0;
            default: code = 4'd0;
        endcase
    end

    always_comb begin
        hp = 16'd1;
        case (code)
            4'd1: hp = HP_C4;
            4'd2: hp = HP_D4;
            4'd3: hp = HP_E4;
            4'd4: hp = HP_F4;
            4'd5: hp = HP_G4;
            4'd6: hp = HP_A4;
            4'd7: hp = HP_B4;
            4'd8: hp = HP_C5;
            default: hp = 16'd1;
        endcase
    end

    always_comb begin
        led = 1'b0;
        case (state)
            S_PLAY:   led = (beat_cnt < BEAT_HALF);
            S_SNOOZE: led = 1'b1;
            default:  led = 1'b0;
        endcase
    end

    // Stop is checked first in every state, so it beats a tick, a snooze or a done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            beat_cnt     <= '0;
            pass_cnt     <= '0;
            snooze_cnt   <= '0;
            snooze_beats <= '0;
            note_idx     <= 4'd0;
            done         <= 1'b0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            snooze_q     <= 1'b0;
        end else begin
            start_q  <= start;
            stop_q   <= stop;
            snooze_q <= snooze;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    beat_cnt     <= '0;
                    pass_cnt     <= '0;
                    snooze_beats <= '0;
                    note_idx     <= 4'd0;
                    if (start_e && !stop_e) begin
                        state      <= S_PLAY;
                        snooze_cnt <= '0;
                    end
                end
                S_PLAY: begin
                    if (stop_e) begin
                        state    <= S_IDLE;
                        beat_cnt <= '0;
                        pass_cnt <= '0;
                        note_idx <= 4'd0;
                    end else if (snooze_go) begin
                        state        <= S_SNOOZE;
                        snooze_cnt   <= snooze_cnt + 1'b1;
                        snooze_beats <= '0;
                        beat_cnt     <= '0;
                    end else if (tick) begin
                        beat_cnt <= '0;
                        if (note_idx == NOTE_LAST) begin
                            note_idx <= 4'd0;
                            pass_cnt <= pass_cnt + 1'b1;
                            if (REPEATS != 0 && pass_cnt == PASS_LAST) begin
                                state <= S_IDLE;
                                done  <= 1'b1;
                            end
                        end else begin
                            note_idx <= note_idx + 4'd1;
                        end
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                S_SNOOZE: begin
                    if (stop_e) begin
                        state    <= S_IDLE;
                        beat_cnt <= '0;
                        pass_cnt <= '0;
                        note_idx <= 4'd0;
                    end else if (tick) begin
                        beat_cnt <= '0;
                        if (snooze_beats == SNOOZE_LAST) begin
                            state    <= S_PLAY;
                            note_idx <= 4'd0;
                            pass_cnt <= '0;
                        end else begin
                            snooze_beats <= snooze_beats + 1'b1;
                        end
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The tone restarts from a low level at every note boundary and state change.
    always_ff @(posedge clk) begin
        if (rst || !tone_run) begin
            tone_cnt <= 16'd0;
            piezo    <= 1'b0;
        end else if (tone_cnt == hp - 16'd1) begin
            tone_cnt <= 16'd0;
            piezo    <= ~piezo;
        end else begin
            tone_cnt <= tone_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_alarm_melody.sv
// Self-checking bench for alarm_melody: a table of timed input records whose
// expected outputs go through a scoreboard queue, plus a hand-written done-latency run.
module tb_alarm_melody;

    typedef struct {
        logic       rst, start, stop, snooze;
        int         cycles;
        logic       piezo, led, busy;
        logic [3:0] note;
        logic       done;
    } vec_t;

    typedef struct {
        logic       piezo, led, busy;
        logic [3:0] note;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, start, stop, snooze;
    logic       piezo, led, busy, done;
    logic [3:0] note_idx;

    int   checks = 0;
    int   errors = 0;
    int   done_cycles = 0;
    vec_t vecs[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alarm_melody #(
        .CLK_HZ(20000), .BEAT_DIV(100), .SEQ_LEN(4),
        .REPEATS(2), .SNOOZE_BEATS(3), .MAX_SNOOZE(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .snooze(snooze),
        .piezo(piezo), .led(led), .busy(busy), .note_idx(note_idx), .done(done)
    );

    always @(negedge clk) begin
        if (done === 1'b1) done_cycles++;
    end

    function automatic vec_t mk(input logic r, input logic st, input logic sp, input logic sz,
                                input int c, input logic ep, input logic el, input logic eb,
                                input logic [3:0] en, input logic ed);
        vec_t v;
        v.rst = r; v.start = st; v.stop = sp; v.snooze = sz; v.cycles = c;
        v.piezo = ep; v.led = el; v.busy = eb; v.note = en; v.done = ed;
        return v;
    endfunction

    task automatic compare(input string what, input int idx, input logic [3:0] act, input logic [3:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s (step %0d): got %0d, want %0d", what, idx, act, want);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        rst = v.rst; start = v.start; stop = v.stop; snooze = v.snooze;
        e.piezo = v.piezo; e.led = v.led; e.busy = v.busy; e.note = v.note; e.done = v.done;
        exp_q.push_back(e);
        repeat (v.cycles) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input int idx);
        exp_t e;
        if (exp_q.size() == 0) begin
            compare("scoreboard empty", idx, 4'd1, 4'd0);
            return;
        end
        e = exp_q.pop_front();
        compare("piezo", idx, {3'b0, piezo}, {3'b0, e.piezo});
        compare("led", idx, {3'b0, led}, {3'b0, e.led});
        compare("busy", idx, {3'b0, busy}, {3'b0, e.busy});
        compare("note_idx", idx, note_idx, e.note);
        compare("done", idx, {3'b0, done}, {3'b0, e.done});
    endtask

    initial begin
        int cnt;
        rst = 1'b1; start = 1'b0; stop = 1'b0; snooze = 1'b0;

        // reset
        vecs.push_back(mk(1,0,0,0,   3, 0,0,0,4'd0,0));
        // full alarm: two passes then auto-stop
        vecs.push_back(mk(0,1,0,0,   1, 0,1,1,4'd0,0));
        vecs.push_back(mk(0,0,0,0,  37, 0,1,1,4'd0,0));
        vecs.push_back(mk(0,0,0,0,   1, 1,1,1,4'd0,0));
        vecs.push_back(mk(0,0,0,0,  37, 1,0,1,4'd0,0));
        vecs.push_back(mk(0,0,0,0,   1, 0,0,1,4'd0,0));
        vecs.push_back(mk(0,0,0,0,  24, 0,1,1,4'd1,0));
        vecs.push_back(mk(0,0,0,0,  30, 1,1,1,4'd1,0));
        vecs.push_back(mk(0,0,0,0,  29, 1,0,1,4'd1,0));
        vecs.push_back(mk(0,0,0,0,   1, 0,0,1,4'd1,0));
        vecs.push_back(mk(0,0,0,0,  65, 1,1,1,4'd2,0));
        vecs.push_back(mk(0,0,0,0,  25, 0,0,1,4'd2,0));
        vecs.push_back(mk(0,0,0,0,  69, 1,1,1,4'd3,0));
        vecs.push_back(mk(0,0,0,0,  19, 0,1,1,4'd3,0));
        vecs.push_back(mk(0,0,0,0,  62, 0,1,1,4'd0,0));
        vecs.push_back(mk(0,0,0,0, 100, 0,1,1,4'd1,0));
        vecs.push_back(mk(0,0,0,0, 100, 0,1,1,4'd2,0));
        vecs.push_back(mk(0,0,0,0, 100, 0,1,1,4'd3,0));
        vecs.push_back(mk(0,0,0,0,  99, 1,0,1,4'd3,0));
        vecs.push_back(mk(0,0,0,0,   1, 0,0,0,4'd0,1));
        vecs.push_back(mk(0,0,0,0,   1, 0,0,0,4'd0,0));
        // snooze in beat 1, silent for 3 beats, then a fresh 2-pass run; second snooze ignored
        vecs.push_back(mk(0,1,0,0,   1, 0,1,1,4'd0,0));
        vecs.push_back(mk(0,0,0,0, 140, 1,1,1,4'd1,0));
        vecs.push_back(mk(0,0,0,1,   1, 0,1,1,4'd1,0));
        vecs.push_back(mk(0,0,0,0, 299, 0,1,1,4'd1,0));
        vecs.push_back(mk(0,0,0,0,   1, 0,1,1,4'd0,0));
        vecs.push_back(mk(0,0,0,1,   1, 0,1,1,4'd0,0));
        vecs.push_back(mk(0,0,0,0,  37, 1,1,1,4'd0,0));
        vecs.push_back(mk(0,0,0,0, 761, 1,0,1,4'd3,0));
        vecs.push_back(mk(0,0,0,0,   1, 0,0,0,4'd0,1));
        // stop at cycle 150, then replay from note 0
        vecs.push_back(mk(0,1,0,0,   1, 0,1,1,4'd0,0));
        vecs.push_back(mk(0,0,0,0, 149, 1,1,1,4'd1,0));
        vecs.push_back(mk(0,0,1,0,   1, 0,0,0,4'd0,0));
        vecs.push_back(mk(0,0,0,0,   5, 0,0,0,4'd0,0));
        vecs.push_back(mk(0,1,0,0,   1, 0,1,1,4'd0,0));
        vecs.push_back(mk(0,0,0,0,  99, 0,0,1,4'd0,0));
        vecs.push_back(mk(0,0,0,0,   1, 0,1,1,4'd1,0));
        vecs.push_back(mk(0,0,1,0,   1, 0,0,0,4'd0,0));
        vecs.push_back(mk(0,0,0,0,   2, 0,0,0,4'd0,0));
        // stop and start together from IDLE
        vecs.push_back(mk(0,1,1,0,   1, 0,0,0,4'd0,0));
        vecs.push_back(mk(0,0,0,0,   3, 0,0,0,4'd0,0));
        // stop on the final tick suppresses done
        vecs.push_back(mk(0,1,0,0,   1, 0,1,1,4'd0,0));
        vecs.push_back(mk(0,0,0,0, 799, 1,0,1,4'd3,0));
        vecs.push_back(mk(0,0,1,0,   1, 0,0,0,4'd0,0));
        vecs.push_back(mk(0,0,0,0,   1, 0,0,0,4'd0,0));
        // start held for 2000 cycles: one alarm, no restart
        vecs.push_back(mk(0,1,0,0,   1, 0,1,1,4'd0,0));
        vecs.push_back(mk(0,1,0,0, 799, 1,0,1,4'd3,0));
        vecs.push_back(mk(0,1,0,0,   1, 0,0,0,4'd0,1));
        vecs.push_back(mk(0,1,0,0,1198, 0,0,0,4'd0,0));
        vecs.push_back(mk(0,0,0,0,   2, 0,0,0,4'd0,0));
        // reset while playing
        vecs.push_back(mk(0,1,0,0,   1, 0,1,1,4'd0,0));
        vecs.push_back(mk(0,0,0,0,  60, 1,0,1,4'd0,0));
        vecs.push_back(mk(1,0,0,0,   1, 0,0,0,4'd0,0));
        vecs.push_back(mk(0,0,0,0,   2, 0,0,0,4'd0,0));
        // snooze on the tick that would finish the last pass
        vecs.push_back(mk(0,1,0,0,   1, 0,1,1,4'd0,0));
        vecs.push_back(mk(0,0,0,0, 799, 1,0,1,4'd3,0));
        vecs.push_back(mk(0,0,0,1,   1, 0,1,1,4'd3,0));
        vecs.push_back(mk(0,0,0,0, 300, 0,1,1,4'd0,0));
        vecs.push_back(mk(0,0,1,0,   1, 0,0,0,4'd0,0));
        vecs.push_back(mk(0,0,0,0,   1, 0,0,0,4'd0,0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end

        // done latency: exactly 800 cycles after PLAY entry, one cycle wide
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (done !== 1'b1 && cnt < 1000) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
        compare("done latency", 900, cnt[3:0], 4'(800));
        checks++;
        if (cnt != 800) begin
            errors++;
            $display("[TB] FAIL done latency cycles: got %0d, want 800", cnt);
        end
        compare("busy at done", 901, {3'b0, busy}, 4'd0);
        @(posedge clk);
        @(negedge clk);
        compare("done width", 902, {3'b0, done}, 4'd0);

        checks++;
        if (done_cycles != 4) begin
            errors++;
            $display("[TB] FAIL done high cycles total: got %0d, want 4", done_cycles);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alarm_melody.md
# alarm_melody

Parametrised alarm sound generator. It plays a built-in melody on a piezo output and drives an indicator LED. It adds snooze, a repeat limit, auto-stop and a done pulse, none of which the single-beat alarm path offers. It sits between the keypad/front-panel inputs and the piezo pin, and its beat clock enable is derived internally, so no separate clock divider is needed.

## Interface
- CLK_HZ, 1000000, system clock frequency; used to derive tone half-periods.
- BEAT_DIV, 250000, clk cycles per beat (≥4).
- SEQ_LEN, 16, melody notes played per pass (1..16).
- REPEATS, 3, passes before auto-stop; 0 = play until stopped.
- SNOOZE_BEATS, 40, silent beats per snooze (≥1).
- MAX_SNOOZE, 3, snoozes honoured per alarm; later snooze requests are ignored.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  arm/ring request; rising edge.
- stop  in  1  cancel; rising edge.
- snooze  in  1  snooze request; rising edge.
- piezo  out  1  square-wave tone.
- led  out  1  indicator.
- busy  out  1  state ≠ IDLE.
- note_idx  out  4  current melody index.
- done  out  1  one-cycle pulse on auto-stop after REPEATS passes.

## Operation
- Inputs are synchronous and debounced upstream. Each input has a registered previous value. An edge is `in & ~prev`.
- Edge priority, same cycle: stop > snooze > start.
- States: IDLE, PLAY, SNOOZE.
- IDLE: start edge → PLAY. Clear note_idx, beat counter, pass counter and snooze counter.
- PLAY: stop edge → IDLE.
- PLAY: snooze edge while snooze count < MAX_SNOOZE → SNOOZE. Increment snooze count and clear the beat counter.
- PLAY: a start edge is ignored.
- SNOOZE: stop → IDLE.
- SNOOZE: after SNOOZE_BEATS beat ticks → PLAY, with note_idx=0, pass counter=0 and beat counter=0. The snooze count is kept.
- SNOOZE: start and snooze edges are ignored.
- Beat tick: the beat counter counts 0..BEAT_DIV-1 in PLAY/SNOOZE and is held at 0 in IDLE. A tick is counter = BEAT_DIV-1.
- On a tick in PLAY:
  - note_idx increments.
  - At SEQ_LEN-1, note_idx wraps to 0 and the pass counter increments.
  - If REPEATS≠0 and this completes pass REPEATS: go to IDLE and pulse done.
- Melody ROM, codes by index 0..15: 1,3,5,8,0,8,5,3,1,0,1,3,5,8,8,0.
- Code → note: 0 rest, 1 C4 262 Hz, 2 D4 294, 3 E4 330, 4 F4 349, 5 G4 392, 6 A4 440, 7 B4 494, 8 C5 523.
- Half-period HP = CLK_HZ/(2·f), truncated, computed at elaboration. The tone counter is 16 bits wide.
- Tone generation:
  - The tone counter counts 0..HP-1.
  - piezo toggles when the counter reaches HP-1.
  - The counter and piezo are forced to 0 on every beat tick, on state entry, in rest, SNOOZE and IDLE.
- LED:
  - IDLE: 0.
  - PLAY: 1 while beat counter < BEAT_DIV/2, else 0.
  - SNOOZE: steady 1.

## Timing
- Reset values: piezo=0, led=0, busy=0, note_idx=0, done=0, state IDLE. All counters and prev registers are 0.
- Start latency: with start first sampled high at edge k, busy=1 after edge k. The first piezo rise happens HP edges later.
- The first beat tick occurs BEAT_DIV cycles after PLAY entry.
- done is high for exactly one cycle, coincident with busy falling.
- Stop takes effect at the edge that samples it, from any state. All outputs return to reset values after that edge, except that done stays 0.
- A stop edge arriving on a tick cycle wins: no note advance and no done pulse.
- A snooze edge arriving on the tick cycle that completes the final pass: snooze wins, provided the count allows it.
- A held input produces only one edge. Release and re-press is required.

## Test plan
- Bench parameters: CLK_HZ=20000, BEAT_DIV=100, SEQ_LEN=4, REPEATS=2, SNOOZE_BEATS=3, MAX_SNOOZE=1. Half-periods: C4=38, E4=30, G4=25, C5=19.
- Reset then start pulse:
  - busy rises one cycle later.
  - piezo toggles every 38 cycles during beat 0, every 30 during beat 1, every 25 during beat 2, every 19 during beat 3.
  - led high for 50 of every 100 cycles.
- Auto-stop: after 800 cycles of PLAY, done pulses once, busy falls, and piezo and led are 0. note_idx has sequenced 0,1,2,3,0,1,2,3.
- Snooze during beat 1:
  - piezo is 0 and led is 1 for 300 cycles.
  - Then PLAY restarts at note_idx 0 with the full 2 passes.
  - A second snooze is ignored.
- Stop at cycle 150 of PLAY: IDLE on the next cycle, all outputs 0, no done. A later start replays from note 0.
- stop and start asserted in the same cycle from IDLE: state remains IDLE.
- start held high for 2000 cycles: only one alarm plays, and no restart after done.
